// File: rtl/seg7_link_if.sv
// Serial 7-segment link: shift clock, serial data, refresh enable and clear.
// The transmitter drives the master side; the display receiver takes the slave side.
`timescale 1ns/1ps
interface seg7_link_if;
  logic seg_clk;
  logic seg_sout;
  logic SEG_PEN;
  logic seg_clrn;

  modport master (output seg_clk, output seg_sout, output SEG_PEN, output seg_clrn);
  modport slave  (input  seg_clk, input  seg_sout, input  SEG_PEN, input  seg_clrn);
endinterface

// File: rtl/seg7_serial_rx.sv
// Display-side receiver for the serial 7-segment link. Rebuilds the segment
// frame from the serial stream, latches it on the refresh strobe, and scans
// it onto a locally multiplexed 8-digit common-anode display.
`timescale 1ns/1ps
module seg7_serial_rx #(
  parameter int FRAME_BITS  = 64,
  parameter int SCAN_W      = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_link_if.slave            link,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [7:0]            frame_cnt,
  output logic [7:0]            AN,
  output logic [7:0]            SEGMENT
);

  // Bit counter must hold FRAME_BITS+1, the overrun marker.
  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] clk_sync_r, sout_sync_r, pen_sync_r, clrn_sync_r;
  logic                   clk_prev_r, pen_prev_r;
  logic                   clk_s, sout_s, pen_s, clrn_s;
  logic                   clk_rise_s, pen_rise_s;

  logic [FRAME_BITS-1:0]  shreg_r, shreg_s;
  logic [CNT_W-1:0]       bit_cnt_r, bit_cnt_s;
  logic                   accept_s, reject_s;

  logic [FRAME_BITS-1:0]  frame_r;
  logic                   frame_valid_r, frame_err_r;
  logic [7:0]             frame_cnt_r;

  logic [SCAN_W-1:0]      scan_cnt_r;
  logic [2:0]             idx_s;
  logic [7:0]             an_r, segment_r;

  // Synchronize the four asynchronous link inputs; resets match the idle link.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_r  <= '0;
      sout_sync_r <= '1;
      pen_sync_r  <= '0;
      clrn_sync_r <= '1;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0],  link.seg_clk};
      sout_sync_r <= {sout_sync_r[SYNC_STAGES-2:0], link.seg_sout};
      pen_sync_r  <= {pen_sync_r[SYNC_STAGES-2:0],  link.SEG_PEN};
      clrn_sync_r <= {clrn_sync_r[SYNC_STAGES-2:0], link.seg_clrn};
    end
  end

  assign clk_s  = clk_sync_r[SYNC_STAGES-1];
  assign sout_s = sout_sync_r[SYNC_STAGES-1];
  assign pen_s  = pen_sync_r[SYNC_STAGES-1];
  assign clrn_s = clrn_sync_r[SYNC_STAGES-1];

  // Edge-detect history for the shift clock and refresh strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_prev_r <= 1'b0;
      pen_prev_r <= 1'b0;
    end else begin
      clk_prev_r <= clk_s;
      pen_prev_r <= pen_s;
    end
  end

  assign clk_rise_s = clk_s & ~clk_prev_r;
  assign pen_rise_s = pen_s & ~pen_prev_r;

  // Next shift/count state: clear dominates, shift is applied before the latch check.
  always_comb begin
    shreg_s   = shreg_r;
    bit_cnt_s = bit_cnt_r;
    accept_s  = 1'b0;
    reject_s  = 1'b0;
    if (!clrn_s) begin
      shreg_s   = '0;
      bit_cnt_s = '0;
    end else begin
      if (clk_rise_s) begin
        shreg_s = {shreg_r[FRAME_BITS-2:0], sout_s};
        if (bit_cnt_r != CNT_OVR) begin
          bit_cnt_s = bit_cnt_r + CNT_W'(1);
        end else begin
          bit_cnt_s = bit_cnt_r;
        end
      end else begin
        shreg_s = shreg_r;
      end
      if (pen_rise_s) begin
        if (bit_cnt_s == CNT_FULL) begin
          accept_s = 1'b1;
        end else begin
          reject_s = 1'b1;
        end
        bit_cnt_s = '0;
      end else begin
        accept_s = 1'b0;
      end
    end
  end

  // Receive state: shift register, bit count, accepted frame and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_r       <= '1;
      bit_cnt_r     <= '0;
      frame_r       <= '1;
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      frame_cnt_r   <= 8'd0;
    end else begin
      shreg_r       <= shreg_s;
      bit_cnt_r     <= bit_cnt_s;
      frame_valid_r <= accept_s;
      frame_err_r   <= reject_s;
      if (accept_s) begin
        frame_r     <= shreg_s;
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end
    end
  end

  assign idx_s = scan_cnt_r[SCAN_W-1 -: 3];

  // Free-running scan; anode and segment bytes registered together to avoid ghosting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_r <= '0;
      an_r       <= 8'hFF;
      segment_r  <= 8'hFF;
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
      an_r       <= ~(8'd1 << idx_s);
      segment_r  <= frame_r[{idx_s, 3'b000} +: 8];
    end
  end

  assign frame       = frame_r;
  assign frame_valid = frame_valid_r;
  assign frame_err   = frame_err_r;
  assign frame_cnt   = frame_cnt_r;
  assign AN          = an_r;
  assign SEGMENT     = segment_r;

endmodule

// File: tb/tb_seg7_serial_rx.sv
// Directed self-checking bench for seg7_serial_rx (scan divider shortened to 5 bits).
`timescale 1ns/1ps
module tb_seg7_serial_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] frame;
  logic        frame_valid, frame_err;
  logic [7:0]  frame_cnt, AN, SEGMENT;

  int tests_run    = 0;
  int tests_failed = 0;
  int valid_seen   = 0;
  int err_seen     = 0;

  seg7_link_if link();

  seg7_serial_rx #(.FRAME_BITS(64), .SCAN_W(5), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .link(link),
    .frame(frame), .frame_valid(frame_valid), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .AN(AN), .SEGMENT(SEGMENT)
  );

  always #5 clk = ~clk;

  // Count status pulses seen by the display side.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) valid_seen++;
    if (frame_err === 1'b1) err_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    link.seg_sout = b;
    tick(2);
    link.seg_clk = 1'b1;
    tick(4);
    link.seg_clk = 1'b0;
    tick(2);
  endtask

  // Send the top n bits of v, MSB first.
  task automatic send_n(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[63-i]);
  endtask

  task automatic pulse_pen(output logic v_early, output logic v_at);
    valid_seen = 0;
    err_seen   = 0;
    link.SEG_PEN = 1'b1;
    tick(2);
    v_early = frame_valid;
    tick(1);
    v_at = frame_valid;
    tick(3);
    link.SEG_PEN = 1'b0;
    tick(6);
  endtask

  task automatic check_status(input string name, input logic [63:0] exp_frame,
                              input int exp_v, input int exp_e, input logic [7:0] exp_cnt);
    tests_run++;
    if (frame !== exp_frame) begin
      tests_failed++;
      $display("FAIL %s frame: got %h expected %h", name, frame, exp_frame);
    end
    tests_run++;
    if (valid_seen !== exp_v) begin
      tests_failed++;
      $display("FAIL %s valid pulses: got %0d expected %0d", name, valid_seen, exp_v);
    end
    tests_run++;
    if (err_seen !== exp_e) begin
      tests_failed++;
      $display("FAIL %s err pulses: got %0d expected %0d", name, err_seen, exp_e);
    end
    tests_run++;
    if (frame_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL %s frame_cnt: got %0d expected %0d", name, frame_cnt, exp_cnt);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests_run++;
    if (frame !== 64'hFFFF_FFFF_FFFF_FFFF || frame_cnt !== 8'd0 || frame_valid !== 1'b0 ||
        frame_err !== 1'b0 || AN !== 8'hFF || SEGMENT !== 8'hFF) begin
      tests_failed++;
      $display("FAIL %s: got frame=%h cnt=%0d v=%b e=%b AN=%h SEG=%h expected all-ones/0/0/0/FF/FF",
               name, frame, frame_cnt, frame_valid, frame_err, AN, SEGMENT);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    tick(4);
  endtask

  task automatic test_basic_frame();
    logic ve, va;
    send_n(64'h0123_4567_89AB_CDEF, 64);
    pulse_pen(ve, va);
    tests_run++;
    if (ve !== 1'b0 || va !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic latency: got valid@2=%b valid@3=%b expected 0 1", ve, va);
    end
    check_status("basic", 64'h0123_4567_89AB_CDEF, 1, 0, 8'd1);
  endtask

  task automatic test_bad_count();
    logic ve, va;
    send_n(64'h1111_2222_3333_4444, 63);
    pulse_pen(ve, va);
    check_status("short63", 64'h0123_4567_89AB_CDEF, 0, 1, 8'd1);
    send_n(64'h5555_6666_7777_8888, 64);
    send_bit(1'b1);
    pulse_pen(ve, va);
    check_status("overrun65", 64'h0123_4567_89AB_CDEF, 0, 1, 8'd1);
    send_n(64'hDEAD_BEEF_0BAD_F00D, 64);
    pulse_pen(ve, va);
    check_status("after_err", 64'hDEAD_BEEF_0BAD_F00D, 1, 0, 8'd2);
  endtask

  task automatic test_clear();
    logic ve, va;
    send_n(64'hFEDC_BA98_7654_3210, 30);
    link.seg_clrn = 1'b0;
    tick(5);
    link.seg_clrn = 1'b1;
    tick(4);
    tests_run++;
    if (frame !== 64'hDEAD_BEEF_0BAD_F00D) begin
      tests_failed++;
      $display("FAIL clear_keeps_frame: got %h expected %h", frame, 64'hDEAD_BEEF_0BAD_F00D);
    end
    send_n(64'hFFFF_0000_AAAA_5555, 64);
    pulse_pen(ve, va);
    check_status("after_clear", 64'hFFFF_0000_AAAA_5555, 1, 0, 8'd3);
  endtask

  task automatic test_simultaneous();
    logic [63:0] v;
    logic ve, va;
    v = 64'h1357_9BDF_2468_ACE0;
    send_n(v, 63);
    valid_seen = 0;
    err_seen   = 0;
    link.seg_sout = v[0];
    tick(2);
    link.seg_clk = 1'b1;
    link.SEG_PEN = 1'b1;
    tick(4);
    link.seg_clk = 1'b0;
    tick(2);
    link.SEG_PEN = 1'b0;
    tick(6);
    check_status("shift_plus_latch", v, 1, 0, 8'd4);
    send_n(64'h0F0F_0F0F_0F0F_0F0F, 64);
    valid_seen = 0;
    err_seen   = 0;
    link.seg_clrn = 1'b0;
    link.SEG_PEN  = 1'b1;
    tick(4);
    link.SEG_PEN  = 1'b0;
    tick(2);
    link.seg_clrn = 1'b1;
    tick(6);
    check_status("clear_plus_latch", v, 0, 0, 8'd4);
    pulse_pen(ve, va);
    check_status("after_clear_latch_empty", v, 0, 1, 8'd4);
  endtask

  task automatic test_scan();
    logic [63:0] f;
    logic [7:0]  prev_an, exp_an, exp_seg;
    logic ve, va;
    int found, k;
    f = 64'hC0F9_A4B0_9992_82F8;
    send_n(f, 64);
    pulse_pen(ve, va);
    check_status("scan_load", f, 1, 0, 8'd5);
    found = 0;
    prev_an = AN;
    for (int i = 0; i < 40 && found == 0; i++) begin
      tick(1);
      if (prev_an === 8'h7F && AN === 8'hFE) found = 1;
      else prev_an = AN;
    end
    tests_run++;
    if (found == 0) begin
      tests_failed++;
      $display("FAIL scan_wrap: got no 7F->FE transition in 40 cycles, expected one");
    end else begin
      for (int j = 0; j < 32; j++) begin
        k = j / 4;
        exp_an = ~(8'd1 << k);
        exp_seg = f[8*k +: 8];
        tests_run++;
        if (AN !== exp_an || SEGMENT !== exp_seg) begin
          tests_failed++;
          $display("FAIL scan step %0d: got AN=%h SEG=%h expected AN=%h SEG=%h",
                   j, AN, SEGMENT, exp_an, exp_seg);
        end
        tick(1);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic ve, va;
    send_n(64'h7777_8888_9999_AAAA, 40);
    rst = 1'b0;
    #1;
    check_reset_outputs("midframe_reset_async");
    tick(3);
    check_reset_outputs("midframe_reset_held");
    rst = 1'b1;
    tick(4);
    send_n(64'hA5A5_5A5A_C3C3_3C3C, 64);
    pulse_pen(ve, va);
    check_status("post_reset", 64'hA5A5_5A5A_C3C3_3C3C, 1, 0, 8'd1);
  endtask

  initial begin
    link.seg_clk  = 1'b0;
    link.seg_sout = 1'b1;
    link.SEG_PEN  = 1'b0;
    link.seg_clrn = 1'b1;
    test_reset();
    test_basic_frame();
    test_bad_count();
    test_clear();
    test_simultaneous();
    test_scan();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
